datapath_op_sequencer: RTL and testbench
========================================

Name: datapath_op_sequencer

Overview:
Command-level sequencer for the flag-driven accumulator datapath that consumes the 5-bit control-point word cp and returns the V (overflow) and Z (zero) flags. It accepts one 2-bit operation per start/busy/done handshake and walks the datapath through fetch, execute and flag-test steps. LOOP repeats execute until Z is set or an iteration limit is reached. It sits between the host command interface and the datapath and is the only driver of cp.

Parameters:
ITER_W, 4, width of iteration counter
MAX_ITER, 15, maximum EXEC passes for LOOP before fault; must be less than or equal to 2**ITER_W-1

Ports:
clk  in  1  system clock, rising edge
clr  in  1  asynchronous active-low reset
start  in  1  command strobe, sampled only in IDLE
op  in  2  opcode: 00 ADD, 01 SUB, 10 LOOP (decrement until Z), 11 CLR; latched on accepted start
abort  in  1  synchronous cancel, any non-IDLE state
V  in  1  datapath overflow flag, sampled in TEST
Z  in  1  datapath zero flag, sampled in TEST
cp  out  5  control points: [4] ldA, [3] ldB, [2] alu_sub, [1] wr_acc, [0] clr_acc
busy  out  1  high in every state except IDLE
done  out  1  one-cycle completion pulse
err  out  1  sticky fault flag; cleared on next accepted start
iter_cnt  out  ITER_W  EXEC passes in current command
state  out  6  one-hot present state (debug)

Behaviour:
- Reset (clr=0, async): state=IDLE, op_q=00, iter_cnt=0, err=0; cp=00000, busy=0, done=0.
- State, op_q, iter_cnt and err are registers. cp, busy and done decode combinationally from state and op_q only, never from V, Z or start.
- One-hot encoding: IDLE=100000, FETCH=010000, EXEC=001000, TEST=000100, DONE=000010, FAULT=000001. Any illegal code goes to IDLE on the next edge with cp=00000.
- IDLE: cp=00000. If start=1, latch op into op_q, set iter_cnt=0, clear err, go to FETCH. If start=0, stay in IDLE.
- FETCH: if op_q=CLR, cp=00001 and go to DONE. Otherwise cp=11000 and go to EXEC.
- EXEC: cp=0,0,sub,1,0, where sub=1 for SUB or LOOP and 0 for ADD. iter_cnt increments and saturates at all-ones. Go to TEST.
- TEST: cp=00000. Priority order:
  1. V=1 goes to FAULT.
  2. ADD or SUB goes to DONE.
  3. LOOP with Z=1 goes to DONE.
  4. LOOP with Z=0 and iter_cnt==MAX_ITER goes to FAULT.
  5. Otherwise go to EXEC.
- DONE: done=1, cp=00000, go to IDLE.
- FAULT: done=1, err set to 1 on entry, cp=00000, go to IDLE.
- Latency from start to done: 4 cycles for ADD/SUB (FETCH, EXEC, TEST, DONE), 2 cycles for CLR, 2+2N cycles for a LOOP of N passes.
- start while busy=1 is ignored; no queuing. start in the same cycle as DONE or FAULT is also ignored. A new start is accepted no earlier than the cycle after done.
- abort=1 in any non-IDLE state goes to IDLE on the next edge. No done pulse. err and iter_cnt are held. abort has priority over all other transitions. abort in IDLE has no effect, and start is still honoured.
- Reset asserted mid-command forces IDLE immediately, cp=00000 asynchronously, and no done pulse.
- iter_cnt holds its final value after DONE or FAULT until the next accepted start.

Decomposition:
- Shared package: one-hot state constants, opcode constants (OP_ADD, OP_SUB, OP_LOOP, OP_CLR), and cp words CP_IDLE=00000, CP_FETCH=11000, CP_CLR=00001, CP_ADD=00010, CP_SUB=00110.
- One natural sub-module: seq_iter_counter, a saturating ITER_W counter with clear/enable and async active-low clr, reused by later sequencers.

Test Plan:
- ADD, V=0: start=1, op=00 at cycle 0. Expect cp=11000 at c1, 00010 at c2, 00000 at c3, done=1 at c4, busy=0 at c5, err=0, iter_cnt=1.
- SUB, V=1 in TEST: cp=00110 in EXEC; FAULT at c4 with done=1; err=1 and stays 1 until the next start, which clears it.
- LOOP, Z=1 on the 3rd TEST: three EXEC cycles with cp=00110; done at cycle 2+2*3=8; iter_cnt=3; err=0.
- LOOP with Z held 0, MAX_ITER=15: 15 EXEC passes, then FAULT with done=1; err=1; iter_cnt=15; no 16th EXEC.
- CLR: cp=00001 at c1, done at c2. A start pulse at c1 (busy) is ignored: no second command and op_q unchanged.
- Abort and reset: abort=1 during EXEC gives IDLE next cycle with no done pulse. Separately, clr=0 mid-LOOP gives cp=00000, state=100000 and busy=0 immediately, before any clk edge.

Source files
------------

// File: rtl/datapath_op_sequencer_pkg.sv
// rtl/datapath_op_sequencer_pkg.sv - shared states, opcodes and control-point words
package datapath_op_sequencer_pkg;

    typedef enum logic [5:0] {
        S_IDLE  = 6'b100000,
        S_FETCH = 6'b010000,
        S_EXEC  = 6'b001000,
        S_TEST  = 6'b000100,
        S_DONE  = 6'b000010,
        S_FAULT = 6'b000001
    } state_e;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_LOOP = 2'b10,
        OP_CLR  = 2'b11
    } op_e;

    // cp bit order: ldA, ldB, alu_sub, wr_acc, clr_acc
    localparam logic [4:0] CP_IDLE  = 5'b00000;
    localparam logic [4:0] CP_FETCH = 5'b11000;
    localparam logic [4:0] CP_CLR   = 5'b00001;
    localparam logic [4:0] CP_ADD   = 5'b00010;
    localparam logic [4:0] CP_SUB   = 5'b00110;

endpackage

// File: rtl/seq_iter_counter.sv
// rtl/seq_iter_counter.sv - saturating iteration counter with sync clear and enable
module seq_iter_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         clear,
    input  logic         en,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (en && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/datapath_op_sequencer.sv
// rtl/datapath_op_sequencer.sv - start/busy/done command sequencer driving datapath cp
module datapath_op_sequencer
    import datapath_op_sequencer_pkg::*;
#(
    parameter int ITER_W   = 4,
    parameter int MAX_ITER = 15
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic              abort,
    input  logic              V,
    input  logic              Z,
    output logic [4:0]        cp,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ITER_W-1:0] iter_cnt,
    output logic [5:0]        state
);

    localparam logic [ITER_W-1:0] MAX_CNT = ITER_W'(MAX_ITER);

    state_e state_q, state_d;
    op_e    op_q, op_d;
    logic   err_q, err_d;
    logic   cnt_clear;
    logic   cnt_en;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= S_IDLE;
            op_q    <= OP_ADD;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d   = S_IDLE;
        op_d      = op_q;
        err_d     = err_q;
        cnt_clear = 1'b0;
        cnt_en    = 1'b0;
        cp        = CP_IDLE;
        busy      = 1'b1;
        done      = 1'b0;

        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    op_d      = op_e'(op);
                    cnt_clear = 1'b1;
                    err_d     = 1'b0;
                    state_d   = S_FETCH;
                end
            end
            S_FETCH: begin
                if (op_q == OP_CLR) begin
                    cp      = CP_CLR;
                    state_d = S_DONE;
                end else begin
                    cp      = CP_FETCH;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                cp      = (op_q == OP_ADD) ? CP_ADD : CP_SUB;
                cnt_en  = 1'b1;
                state_d = S_TEST;
            end
            S_TEST: begin
                if (V) begin
                    state_d = S_FAULT;
                end else if (op_q != OP_LOOP) begin
                    state_d = S_DONE;
                end else if (Z) begin
                    state_d = S_DONE;
                end else if (iter_cnt == MAX_CNT) begin
                    state_d = S_FAULT;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_DONE: begin
                done = 1'b1;
            end
            S_FAULT: begin
                done = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort freezes err and the pass count where they stand.
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            cnt_en  = 1'b0;
        end

        if (state_d == S_FAULT) begin
            err_d = 1'b1;
        end
    end

    seq_iter_counter #(
        .W(ITER_W)
    ) u_iter_counter (
        .clk  (clk),
        .clr_n(clr),
        .clear(cnt_clear),
        .en   (cnt_en),
        .cnt  (iter_cnt)
    );

    assign err   = err_q;
    assign state = state_q;

endmodule

// File: tb/tb_datapath_op_sequencer.sv
// tb/tb_datapath_op_sequencer.sv - scoreboard bench for datapath_op_sequencer
module tb_datapath_op_sequencer;

    logic       clk = 1'b0;
    logic       clr;
    logic       start;
    logic [1:0] op;
    logic       abort;
    logic       V;
    logic       Z;
    logic [4:0] cp;
    logic       busy;
    logic       done;
    logic       err;
    logic [3:0] iter_cnt;
    logic [5:0] state;

    logic v_force;
    int   z_pass;
    bit   chk_cp;

    typedef struct {
        logic       err;
        logic [3:0] iter;
        int         lat;
    } res_t;

    res_t       res_q[$];
    logic [4:0] cp_q[$];
    res_t       mon_r;
    int         lat_cnt = 0;
    int         pass_cnt = 0;
    int         total_cnt = 0;

    datapath_op_sequencer #(.ITER_W(4), .MAX_ITER(15)) dut (
        .clk     (clk),
        .clr     (clr),
        .start   (start),
        .op      (op),
        .abort   (abort),
        .V       (V),
        .Z       (Z),
        .cp      (cp),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .iter_cnt(iter_cnt),
        .state   (state)
    );

    always #5 clk = ~clk;

    // Datapath stand-in: Z rises on the chosen pass, V is forced by the test.
    assign V = v_force;
    assign Z = (z_pass != 0) && (int'(iter_cnt) == z_pass);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        total_cnt++;
        $display("FAIL %s: unexpected event at %0t", name, $time);
    endtask

    always @(negedge clk) begin
        if (busy === 1'b1) begin
            lat_cnt++;
            if (chk_cp) begin
                if (cp_q.size() == 0) fail_now("cp_extra_busy_cycle");
                else check("cp", 32'(cp), 32'(cp_q.pop_front()));
            end
            if (done === 1'b1) begin
                if (res_q.size() == 0) begin
                    fail_now("done_unexpected");
                end else begin
                    mon_r = res_q.pop_front();
                    check("done_err", 32'(err), 32'(mon_r.err));
                    check("done_iter", 32'(iter_cnt), 32'(mon_r.iter));
                    check("done_latency", 32'(lat_cnt), 32'(mon_r.lat));
                end
            end
        end else begin
            lat_cnt = 0;
            if (done === 1'b1) fail_now("done_while_idle");
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] o);
        start = 1'b1;
        op    = o;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            tick();
            n++;
        end
        check("idle_within_budget", 32'(busy), 32'd0);
    endtask

    task automatic push_loop(input int passes);
        cp_q.push_back(5'b11000);
        for (int i = 0; i < passes; i++) begin
            cp_q.push_back(5'b00110);
            cp_q.push_back(5'b00000);
        end
        cp_q.push_back(5'b00000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        clr = 1'b0; start = 1'b0; abort = 1'b0; op = 2'b00;
        v_force = 1'b0; z_pass = 0; chk_cp = 1'b1;
        #12;
        check("rst_state", 32'(state), 32'b100000);
        check("rst_cp", 32'(cp), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_iter", 32'(iter_cnt), 32'd0);
        #3 clr = 1'b1;
        tick();

        // ADD, no overflow
        cp_q.push_back(5'b11000); cp_q.push_back(5'b00010);
        cp_q.push_back(5'b00000); cp_q.push_back(5'b00000);
        res_q.push_back('{1'b0, 4'd1, 4});
        issue(2'b00);
        wait_idle(20);
        check("add_iter_hold", 32'(iter_cnt), 32'd1);
        check("add_err", 32'(err), 32'd0);

        // SUB with overflow in TEST
        v_force = 1'b1;
        cp_q.push_back(5'b11000); cp_q.push_back(5'b00110);
        cp_q.push_back(5'b00000); cp_q.push_back(5'b00000);
        res_q.push_back('{1'b1, 4'd1, 4});
        issue(2'b01);
        wait_idle(20);
        v_force = 1'b0;
        tick(); tick();
        check("sub_err_sticky", 32'(err), 32'd1);

        // LOOP ending on third pass
        z_pass = 3;
        push_loop(3);
        res_q.push_back('{1'b0, 4'd3, 8});
        issue(2'b10);
        check("err_cleared_on_start", 32'(err), 32'd0);
        wait_idle(40);
        z_pass = 0;

        // LOOP hitting the iteration limit
        push_loop(15);
        res_q.push_back('{1'b1, 4'd15, 32});
        issue(2'b10);
        wait_idle(100);
        check("loop_iter_hold", 32'(iter_cnt), 32'd15);
        check("loop_err", 32'(err), 32'd1);

        // CLR, with a start pulse while busy
        cp_q.push_back(5'b00001); cp_q.push_back(5'b00000);
        res_q.push_back('{1'b0, 4'd0, 2});
        issue(2'b11);
        start = 1'b1; op = 2'b00;
        tick();
        start = 1'b0;
        wait_idle(20);
        tick(); tick(); tick();
        check("clr_no_second_cmd", 32'(busy), 32'd0);
        check("clr_iter", 32'(iter_cnt), 32'd0);

        // abort during EXEC
        cp_q.push_back(5'b11000); cp_q.push_back(5'b00010);
        issue(2'b00);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_state", 32'(state), 32'b100000);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_iter_held", 32'(iter_cnt), 32'd0);

        // abort in IDLE does not block start
        abort = 1'b1;
        cp_q.push_back(5'b11000); cp_q.push_back(5'b00010);
        cp_q.push_back(5'b00000); cp_q.push_back(5'b00000);
        res_q.push_back('{1'b0, 4'd1, 4});
        issue(2'b00);
        abort = 1'b0;
        wait_idle(20);

        // async reset mid-LOOP
        chk_cp = 1'b0;
        issue(2'b10);
        repeat (4) tick();
        #2 clr = 1'b0;
        #1;
        check("arst_cp", 32'(cp), 32'd0);
        check("arst_state", 32'(state), 32'b100000);
        check("arst_busy", 32'(busy), 32'd0);
        tick();
        clr = 1'b1;
        tick();
        check("arst_no_done", 32'(done), 32'd0);
        chk_cp = 1'b1;

        check("cp_queue_drained", 32'(cp_q.size()), 32'd0);
        check("res_queue_drained", 32'(res_q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
